decode_exec_ctrl: RTL and testbench

Decode-side producer of the execute-stage control bundle for the pipelined processor. Decodes the 32-bit ARM-subset instruction in D, registers the resulting control word and condition field into the D→E boundary, and presents CondE, FlagWriteE and FlagsE to the condition unit with stall/flush/bubble handling. Owns the D/E control pipeline register; the condition unit consumes its E-side outputs.

---
 rtl/decode_exec_ctrl.sv | 137 +++++++++++++
 tb/tb_decode_exec_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/decode_exec_ctrl.sv
// Decode of the ARM-subset instruction in D and the D/E control pipeline register.
// Every E-side output is taken straight from the register, so no input reaches an output combinationally.
module decode_exec_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic        ValidD,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic [3:0]  FlagsIn,
    output logic [3:0]  CondE,
    output logic [1:0]  FlagWriteE,
    output logic [3:0]  FlagsE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        MemtoRegE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ALUControlE,
    output logic        ValidE,
    output logic        IllegalE
);

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_control;
        logic [1:0] flag_write;
        logic       valid;
        logic       illegal;
        logic [3:0] cond;
        logic [3:0] flags;
    } ctrl_t;

    function automatic ctrl_t bubble_word();
        ctrl_t w;
        w      = '0;
        w.cond = 4'hE;
        return w;
    endfunction

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    logic [3:0] cond;
    logic [1:0] op;
    logic       imm;
    logic [3:0] cmd;
    logic       s_bit;
    logic       unused_instr;

    assign cond         = InstrD[31:28];
    assign op           = InstrD[27:26];
    assign imm          = InstrD[25];
    assign cmd          = InstrD[24:21];
    assign s_bit        = InstrD[20];
    assign unused_instr = ^InstrD[19:0];

    always_comb begin
        logic set_flags;
        logic arith;
        logic undef;
        ctrl_d    = bubble_word();
        set_flags = s_bit;
        arith     = 1'b0;
        undef     = 1'b0;
        if (ValidD) begin
            ctrl_d.valid = 1'b1;
            ctrl_d.cond  = cond;
            ctrl_d.flags = FlagsIn;
            unique case (op)
                2'b00: begin
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.alu_src   = imm;
                    unique case (cmd)
                        4'b0100: begin ctrl_d.alu_control = 2'b00; arith = 1'b1; end
                        4'b0010: begin ctrl_d.alu_control = 2'b01; arith = 1'b1; end
                        4'b0000: ctrl_d.alu_control = 2'b10;
                        4'b1100: ctrl_d.alu_control = 2'b11;
                        4'b1010: begin
                            // CMP only updates flags, so S is implied regardless of the encoding
                            ctrl_d.alu_control = 2'b01;
                            ctrl_d.reg_write   = 1'b0;
                            arith              = 1'b1;
                            set_flags          = 1'b1;
                        end
                        default: undef = 1'b1;
                    endcase
                    ctrl_d.flag_write = {set_flags, set_flags & arith};
                end
                2'b01: begin
                    ctrl_d.alu_src    = 1'b1;
                    ctrl_d.mem_write  = ~s_bit;
                    ctrl_d.mem_to_reg = s_bit;
                    ctrl_d.reg_write  = s_bit;
                end
                2'b10: begin
                    ctrl_d.branch  = 1'b1;
                    ctrl_d.alu_src = 1'b1;
                end
                default: undef = 1'b1;
            endcase
            // An undefined op stays visible in E but with every write-enable cleared
            if (undef) begin
                ctrl_d         = bubble_word();
                ctrl_d.valid   = 1'b1;
                ctrl_d.illegal = 1'b1;
                ctrl_d.cond    = cond;
                ctrl_d.flags   = FlagsIn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            ctrl_q <= bubble_word();
        end else if (!StallE) begin
            ctrl_q <= ctrl_d;
        end
    end

    assign CondE       = ctrl_q.cond;
    assign FlagWriteE  = ctrl_q.flag_write;
    assign FlagsE      = ctrl_q.flags;
    assign RegWriteE   = ctrl_q.reg_write;
    assign MemWriteE   = ctrl_q.mem_write;
    assign MemtoRegE   = ctrl_q.mem_to_reg;
    assign BranchE     = ctrl_q.branch;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign ALUControlE = ctrl_q.alu_control;
    assign ValidE      = ctrl_q.valid;
    assign IllegalE    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_exec_ctrl.sv
// Directed bench for decode_exec_ctrl: hand-decoded instructions, stall/flush/reset priority.
module tb_decode_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD;
    logic        ValidD;
    logic        StallE;
    logic        FlushE;
    logic [3:0]  FlagsIn;
    logic [3:0]  CondE;
    logic [1:0]  FlagWriteE;
    logic [3:0]  FlagsE;
    logic        RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE;
    logic [1:0]  ALUControlE;
    logic        ValidE, IllegalE;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADDS = 32'hE0912003;
    localparam logic [31:0] CMPI = 32'hE3510005;
    localparam logic [31:0] BEQ  = 32'h0A000002;
    localparam logic [31:0] LDR  = 32'hE5912004;
    localparam logic [31:0] STR  = 32'hE5812004;
    localparam logic [31:0] ILL  = 32'hEC000000;
    localparam logic [31:0] EOR  = 32'hE0212003;
    localparam logic [31:0] ORR  = 32'hE1812003;
    localparam logic [31:0] ANDS = 32'hE0112003;
    localparam logic [31:0] SUBS = 32'hE0512003;

    decode_exec_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .InstrD     (InstrD),
        .ValidD     (ValidD),
        .StallE     (StallE),
        .FlushE     (FlushE),
        .FlagsIn    (FlagsIn),
        .CondE      (CondE),
        .FlagWriteE (FlagWriteE),
        .FlagsE     (FlagsE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .MemtoRegE  (MemtoRegE),
        .BranchE    (BranchE),
        .ALUSrcE    (ALUSrcE),
        .ALUControlE(ALUControlE),
        .ValidE     (ValidE),
        .IllegalE   (IllegalE)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fields packed as cond|fw|flags|rw|mw|mr|br|as|alu|valid|illegal
    task automatic check(input string tag, input logic [3:0] cond, input logic [1:0] fw,
                         input logic [3:0] flags, input logic rw, input logic mw, input logic mr,
                         input logic br, input logic as, input logic [1:0] alu,
                         input logic v, input logic ill);
        logic [18:0] obs, exp;
        obs = {CondE, FlagWriteE, FlagsE, RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE,
               ALUControlE, ValidE, IllegalE};
        exp = {cond, fw, flags, rw, mw, mr, br, as, alu, v, ill};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_bubble(input string tag);
        check(tag, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endtask

    initial begin
        reset = 1'b1; InstrD = ADDS; ValidD = 1'b1; StallE = 1'b0; FlushE = 1'b0; FlagsIn = 4'b0100;
        tick(); tick();
        check_bubble("reset");

        reset = 1'b0;
        tick();
        check("adds", 4'hE, 2'b11, 4'b0100, 1, 0, 0, 0, 0, 2'b00, 1, 0);

        InstrD = CMPI; FlagsIn = 4'b0010;
        tick();
        check("cmp_imm", 4'hE, 2'b11, 4'b0010, 0, 0, 0, 0, 1, 2'b01, 1, 0);

        InstrD = BEQ; FlagsIn = 4'b0100;
        tick();
        check("beq", 4'h0, 2'b00, 4'b0100, 0, 0, 0, 1, 1, 2'b00, 1, 0);

        InstrD = LDR; FlagsIn = 4'b0000;
        tick();
        check("ldr", 4'hE, 2'b00, 4'b0000, 1, 0, 1, 0, 1, 2'b00, 1, 0);

        InstrD = STR;
        tick();
        check("str", 4'hE, 2'b00, 4'b0000, 0, 1, 0, 0, 1, 2'b00, 1, 0);

        InstrD = ORR; FlagsIn = 4'b1111;
        tick();
        check("orr", 4'hE, 2'b00, 4'b1111, 1, 0, 0, 0, 0, 2'b11, 1, 0);

        InstrD = ANDS; FlagsIn = 4'b0001;
        tick();
        check("ands", 4'hE, 2'b10, 4'b0001, 1, 0, 0, 0, 0, 2'b10, 1, 0);

        InstrD = SUBS; FlagsIn = 4'b1010;
        tick();
        check("subs", 4'hE, 2'b11, 4'b1010, 1, 0, 0, 0, 0, 2'b01, 1, 0);

        InstrD = ADDS; FlagsIn = 4'b1000;
        tick();
        check("adds_pre_stall", 4'hE, 2'b11, 4'b1000, 1, 0, 0, 0, 0, 2'b00, 1, 0);

        StallE = 1'b1; InstrD = STR; FlagsIn = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_hold%0d", i), 4'hE, 2'b11, 4'b1000, 1, 0, 0, 0, 0, 2'b00, 1, 0);
        end

        FlushE = 1'b1;
        tick();
        check_bubble("stall_and_flush");

        FlushE = 1'b0; StallE = 1'b0;
        tick();
        check("str_after_release", 4'hE, 2'b00, 4'b0001, 0, 1, 0, 0, 1, 2'b00, 1, 0);

        FlushE = 1'b1; InstrD = ADDS;
        tick();
        check_bubble("flush_only");

        FlushE = 1'b0; InstrD = ILL; FlagsIn = 4'b0000;
        tick();
        check("illegal_op11", 4'hE, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 2'b00, 1, 1);

        ValidD = 1'b0;
        tick();
        check_bubble("illegal_not_valid");

        ValidD = 1'b1; InstrD = EOR; FlagsIn = 4'b0110;
        tick();
        check("undef_cmd", 4'hE, 2'b00, 4'b0110, 0, 0, 0, 0, 0, 2'b00, 1, 1);

        ValidD = 1'b0; InstrD = ADDS;
        tick();
        check_bubble("valid_low_adds");

        ValidD = 1'b1;
        tick();
        check("adds_reload", 4'hE, 2'b11, 4'b0110, 1, 0, 0, 0, 0, 2'b00, 1, 0);

        StallE = 1'b1; reset = 1'b1;
        tick();
        check_bubble("reset_mid_stall");

        reset = 1'b0; StallE = 1'b0; InstrD = BEQ; FlagsIn = 4'b1001;
        tick();
        check("beq_after_reset", 4'h0, 2'b00, 4'b1001, 0, 0, 0, 1, 1, 2'b00, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
